// File: rtl/pwm_meter_pkg.sv
// Shared definitions for the PWM measurement path: FSM states and default sizing constants.
package pwm_meter_pkg;

  localparam int unsigned CntWDefault    = 16;
  localparam int unsigned ClkHz          = 50_000_000;
  localparam int unsigned PwmPeriod      = 1000;
  // 1 ms of edge-free input at the system clock rate.
  localparam int unsigned TimeoutDefault = ClkHz / 1000;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRise,
    StHigh,
    StLow
  } state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_meter: 2-FF synchronizer, optional glitch filter
// (PWM_METER_FILT_EN), registered rise/fall strobes.
module pwm_in_sync #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic sync1_q, sync2_q;
  logic prev_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic level;

`ifdef PWM_METER_FILT_EN
  localparam int unsigned FiltW = $clog2(FILT_LEN + 1);

  logic             filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;

  // Flip only once FILT_LEN consecutive samples disagree with the current level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FiltW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  logic unused_filt_len;
  assign unused_filt_len = ^FILT_LEN;
  assign level = sync2_q;
`endif

  always_comb begin
    rise_d = level & ~prev_q;
    fall_d = ~level & prev_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= i_pwm;
      sync2_q <= sync1_q;
      prev_q  <= level;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/pwm_meter.sv
// PWM high-time / period meter with stuck-line detection.
// Define PWM_METER_FILT_EN to insert the FILT_LEN-sample glitch filter on the input.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned CNT_W    = CntWDefault,
  parameter int unsigned TIMEOUT  = TimeoutDefault,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_stuck,
  output logic             o_stuck_lvl
);

  logic level, rise, fall, any_edge;

  pwm_in_sync #(
    .FILT_LEN (FILT_LEN)
  ) u_in_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pwm   (i_pwm),
    .o_level (level),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             lvl_q, lvl_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign any_edge = rise | fall;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    idle_d   = idle_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    lvl_d    = lvl_q;

    if (!i_en) begin
      state_d = StIdle;
      hi_d    = '0;
      per_d   = '0;
      idle_d  = '0;
    end else begin
      if (any_edge) begin
        idle_d = '0;
      end else if (idle_q != CNT_W'(TIMEOUT)) begin
        idle_d = idle_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          state_d = StWaitRise;
          idle_d  = '0;
        end
        StWaitRise: begin
          if (rise) begin
            state_d = StHigh;
            hi_d    = CNT_W'(1);
            per_d   = CNT_W'(1);
          end
        end
        StHigh: begin
          // The cycle in which the fall is seen already belongs to the low phase.
          per_d = sat_inc(per_q);
          if (fall) begin
            state_d = StLow;
          end else begin
            hi_d = sat_inc(hi_q);
          end
        end
        StLow: begin
          if (rise) begin
            high_d   = hi_q;
            period_d = per_q;
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            state_d  = StHigh;
            hi_d     = CNT_W'(1);
            per_d    = CNT_W'(1);
          end else begin
            per_d = sat_inc(per_q);
          end
        end
        default: state_d = StIdle;
      endcase

      // Fires once on reaching TIMEOUT; the counter then parks there until an edge.
      if (state_q != StIdle && !any_edge && idle_q == CNT_W'(TIMEOUT - 1)) begin
        stuck_d = 1'b1;
        lvl_d   = level;
        state_d = StWaitRise;
        hi_d    = '0;
        per_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      per_q    <= '0;
      idle_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      lvl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      per_q    <= per_d;
      idle_q   <= idle_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      lvl_q    <= lvl_d;
    end
  end

  assign o_high      = high_q;
  assign o_period    = period_q;
  assign o_valid     = valid_q;
  assign o_stuck     = stuck_q;
  assign o_stuck_lvl = lvl_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Self-checking bench for pwm_meter: table vectors, randomized periods against a
// period-list model, and hand sequences for stuck, enable drop, glitch and reset.
module tb_pwm_meter;
  import pwm_meter_pkg::*;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 1200;
  localparam int unsigned FL = 4;
`ifdef PWM_METER_FILT_EN
  localparam int unsigned LAT = 3 + FL;
`else
  localparam int unsigned LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          pwm = 1'b0;
  logic [CW-1:0] o_high, o_period;
  logic          o_valid, o_stuck, o_stuck_lvl;

  pwm_meter #(
    .CNT_W    (CW),
    .TIMEOUT  (TO),
    .FILT_LEN (FL)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_pwm       (pwm),
    .o_high      (o_high),
    .o_period    (o_period),
    .o_valid     (o_valid),
    .o_stuck     (o_stuck),
    .o_stuck_lvl (o_stuck_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned h;
    int unsigned l;
    int unsigned eh;
    int unsigned ep;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned got_h[$], got_p[$];
  int unsigned exp_h[$], exp_p[$];
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Capture every reported result; a valid must never last two cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid) begin
        check("valid_single_cycle", 32'(prev_valid), 0);
        got_h.push_back(32'(o_high));
        got_p.push_back(32'(o_period));
      end
      prev_valid = o_valid;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int unsigned h, input int unsigned l);
    pwm = 1'b1;
    cyc(h);
    pwm = 1'b0;
    cyc(l);
  endtask

  // Final rise closes the last period, then an enable blip leaves the meter in WAIT_RISE.
  task automatic trailing();
    drive(10, 20);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(2);
  endtask

  task automatic expect_period(input int unsigned h, input int unsigned l);
    exp_h.push_back(h);
    exp_p.push_back(h + l);
  endtask

  task automatic compare_results(input string tag);
    check({tag, "_count"}, got_h.size(), exp_h.size());
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
      check($sformatf("%s_high[%0d]", tag, i), got_h[i], exp_h[i]);
      check($sformatf("%s_period[%0d]", tag, i), got_p[i], exp_p[i]);
    end
    got_h.delete();
    got_p.delete();
    exp_h.delete();
    exp_p.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_high"}, 32'(o_high), 0);
    check({tag, "_period"}, 32'(o_period), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_stuck"}, 32'(o_stuck), 0);
    check({tag, "_stuck_lvl"}, 32'(o_stuck_lvl), 0);
  endtask

  vec_t        tbl[8];
  int          n_tbl;
  int unsigned mdl_h, mdl_p, rh, rl;

  initial begin
    n_tbl = 0;
    tbl[n_tbl++] = '{250, PwmPeriod - 250, 250, PwmPeriod};
    tbl[n_tbl++] = '{10, 20, 10, 30};
    tbl[n_tbl++] = '{4, 4, 4, 8};
    tbl[n_tbl++] = '{100, 50, 100, 150};
    tbl[n_tbl++] = '{300, 5, 300, 305};
`ifndef PWM_METER_FILT_EN
    tbl[n_tbl++] = '{1, 1, 1, 2};
    tbl[n_tbl++] = '{1, 6, 1, 7};
`endif

    // Reset state
    cyc(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    cyc(2);
    en = 1'b1;
    cyc(5);

    // Table vectors; each period is reported at the following rise
    for (int i = 0; i < n_tbl; i++) begin
      drive(tbl[i].h, tbl[i].l);
      exp_h.push_back(tbl[i].eh);
      exp_p.push_back(tbl[i].ep);
    end
    trailing();
    check("table_stuck", 32'(o_stuck), 0);
    compare_results("table");

    // Randomized periods against the model
    mdl_h = 0;
    mdl_p = 0;
    for (int i = 0; i < 20; i++) begin
      rh = $urandom_range(120, 4);
      rl = $urandom_range(120, 4);
      drive(rh, rl);
      expect_period(rh, rl);
      mdl_h = rh;
      mdl_p = rh + rl;
    end
    trailing();
    compare_results("random");

    // Line held low: stuck low after TIMEOUT, results held
    pwm = 1'b1;
    cyc(20);
    pwm = 1'b0;
    cyc(TO + LAT - 1);
    check("stuck0_early", 32'(o_stuck), 0);
    cyc(3);
    check("stuck0_set", 32'(o_stuck), 1);
    check("stuck0_lvl", 32'(o_stuck_lvl), 0);
    check("stuck0_high_held", 32'(o_high), mdl_h);
    check("stuck0_period_held", 32'(o_period), mdl_p);
    compare_results("stuck0_novalid");

    // Recovery at 50 % duty; first valid clears stuck
    drive(500, 500);
    drive(500, 500);
    expect_period(500, 500);
    check("recover_stuck", 32'(o_stuck), 0);
    check("recover_high", 32'(o_high), 500);

    // Line held high: stuck high, results held
    pwm = 1'b1;
    expect_period(500, 500);
    cyc(LAT + 2);
    check("stuck1_pre", 32'(o_stuck), 0);
    cyc(TO);
    check("stuck1_set", 32'(o_stuck), 1);
    check("stuck1_lvl", 32'(o_stuck_lvl), 1);
    check("stuck1_high_held", 32'(o_high), 500);
    check("stuck1_period_held", 32'(o_period), 1000);
    compare_results("stuck");

    // Enable dropped mid-HIGH: broken period never reported
    pwm = 1'b0;
    cyc(50);
    drive(100, 100);
    expect_period(100, 100);
    pwm = 1'b1;
    cyc(30);
    en = 1'b0;
    cyc(10);
    en = 1'b1;
    cyc(60);
    pwm = 1'b0;
    cyc(100);
    drive(60, 140);
    expect_period(60, 140);
    drive(60, 140);
    expect_period(60, 140);
    trailing();
    check("en_drop_stuck_cleared", 32'(o_stuck), 0);
    compare_results("en_drop");

    // 2-cycle glitch 200 cycles into the LOW phase of a 1000/300 waveform
    drive(300, 700);
    expect_period(300, 700);
    pwm = 1'b1;
    cyc(300);
    pwm = 1'b0;
    cyc(200);
    pwm = 1'b1;
    cyc(2);
    pwm = 1'b0;
    cyc(498);
`ifdef PWM_METER_FILT_EN
    expect_period(300, 700);
`else
    expect_period(300, 200);
    expect_period(2, 498);
`endif
    drive(300, 700);
    expect_period(300, 700);
    trailing();
    compare_results("glitch");

    // Reset mid-LOW clears outputs without a clock edge
    pwm = 1'b1;
    cyc(100);
    pwm = 1'b0;
    cyc(50);
    check("pre_reset_high", 32'(o_high), 300);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    drive(80, 120);
    expect_period(80, 120);
    drive(80, 120);
    expect_period(80, 120);
    trailing();
    compare_results("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
